// File: rtl/config_chain_pkg.sv
// Shared types and helpers for the configuration-chain loader.
// Holds the controller state encoding and the word-count calculation.
package config_chain_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    SHIFT,
    VERIFY,
    DONE
  } state_e;

  function automatic int nwords(input int chainLen, input int wordW);
    return (chainLen + wordW - 1) / wordW;
  endfunction

endpackage

// File: rtl/prog_serializer.sv
// Parallel-in/serial-out driver for the prog chain: one pass of CHAIN_LEN bits, LSB first.
// A load arriving on the last-bit cycle restarts the pass with no gap in prog_en.
module prog_serializer #(
  parameter int CHAIN_LEN = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 load_i,
  input  logic [CHAIN_LEN-1:0] image_i,
  output logic                 prog_in_o,
  output logic                 prog_en_o,
  output logic                 last_bit_o
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);

  logic [CHAIN_LEN-1:0] shiftReg_q;
  logic [CNT_W-1:0]     bitsLeft_q;
  logic                 progIn_q;
  logic                 progEn_q;

  // bitsLeft_q counts the bits still to come after the one currently on prog_in.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shiftReg_q <= '0;
      bitsLeft_q <= '0;
      progIn_q   <= 1'b0;
      progEn_q   <= 1'b0;
    end else if (load_i) begin
      shiftReg_q <= image_i >> 1;
      progIn_q   <= image_i[0];
      progEn_q   <= 1'b1;
      bitsLeft_q <= LAST_IDX;
    end else if (progEn_q) begin
      if (bitsLeft_q == '0) begin
        progEn_q <= 1'b0;
        progIn_q <= 1'b0;
      end else begin
        progIn_q   <= shiftReg_q[0];
        shiftReg_q <= shiftReg_q >> 1;
        bitsLeft_q <= bitsLeft_q - 1'b1;
      end
    end
  end

  assign prog_in_o  = progIn_q;
  assign prog_en_o  = progEn_q;
  assign last_bit_o = progEn_q && (bitsLeft_q == '0);

endmodule

// File: rtl/config_chain_loader.sv
// Master end of the serial configuration chain: collects host words into an image,
// shifts it into the chain and optionally reads it back to confirm the load.
module config_chain_loader
  import config_chain_pkg::*;
#(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              verify_en_i,
  input  logic              cfg_valid_i,
  input  logic [WORD_W-1:0] cfg_data_i,
  output logic              cfg_ready_o,
  output logic              prog_in_o,
  output logic              prog_en_o,
  input  logic              prog_out_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              verify_ok_o
);

  localparam int NWORDS = nwords(CHAIN_LEN, WORD_W);
  localparam int IMG_W  = NWORDS * WORD_W;
  localparam int WCNT_W = $clog2(NWORDS + 1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NWORDS - 1);

  state_e               state_q;
  logic [WCNT_W-1:0]    wordCnt_q;
  logic [CHAIN_LEN-1:0] image_q;
  logic [IMG_W-1:0]     image_d;
  logic [CHAIN_LEN-1:0] cap_q;
  logic [CHAIN_LEN-1:0] cap_d;
  logic                 verifyReq_q;
  logic                 cfgReady_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 verifyOk_q;

  logic accept;
  logic lastWord;
  logic serLoad;
  logic progEn;
  logic progIn;
  logic lastBit;

  assign accept   = (state_q == FILL) && cfg_valid_i && cfgReady_q;
  assign lastWord = accept && (wordCnt_q == LAST_WORD);
  // The readback pass is launched on the last shift cycle so prog_en never drops.
  assign serLoad  = lastWord || ((state_q == SHIFT) && lastBit && verifyReq_q);

  always_comb begin
    image_d = IMG_W'(image_q);
    if (accept) begin
      image_d[int'(wordCnt_q) * WORD_W +: WORD_W] = cfg_data_i;
    end
  end

  // Captures enter at the top so capture j ends up in bit j after a full pass.
  always_comb begin
    cap_d = cap_q >> 1;
    cap_d[CHAIN_LEN-1] = prog_out_i;
  end

  prog_serializer #(
    .CHAIN_LEN (CHAIN_LEN)
  ) u_serializer (
    .clk_i      (prog_clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (serLoad),
    .image_i    (image_d[CHAIN_LEN-1:0]),
    .prog_in_o  (progIn),
    .prog_en_o  (progEn),
    .last_bit_o (lastBit)
  );

  always_ff @(posedge prog_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      wordCnt_q   <= '0;
      image_q     <= '0;
      cap_q       <= '0;
      verifyReq_q <= 1'b0;
      cfgReady_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      verifyOk_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q     <= FILL;
            verifyReq_q <= verify_en_i;
            verifyOk_q  <= 1'b0;
            wordCnt_q   <= '0;
            cfgReady_q  <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        FILL: begin
          if (accept) begin
            image_q <= image_d[CHAIN_LEN-1:0];
            if (lastWord) begin
              cfgReady_q <= 1'b0;
              state_q    <= SHIFT;
            end else begin
              wordCnt_q <= wordCnt_q + 1'b1;
            end
          end
        end
        SHIFT: begin
          if (lastBit) begin
            if (verifyReq_q) begin
              state_q <= VERIFY;
            end else begin
              state_q    <= DONE;
              done_q     <= 1'b1;
              verifyOk_q <= 1'b0;
            end
          end
        end
        VERIFY: begin
          if (progEn) begin
            cap_q <= cap_d;
          end
          if (lastBit) begin
            state_q    <= DONE;
            done_q     <= 1'b1;
            verifyOk_q <= (cap_d == image_q);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cfg_ready_o = cfgReady_q;
  assign prog_in_o   = progIn;
  assign prog_en_o   = progEn;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign verify_ok_o = verifyOk_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader driving a 16-bit shift-register chain model.
// Each step states its expected values by hand; assertions tally evaluated and failed checks.
module tb_config_chain_loader;

  logic       prog_clk;
  logic       rst_n;
  logic       start;
  logic       verify_en;
  logic       cfg_valid;
  logic [7:0] cfg_data;
  logic       cfg_ready;
  logic       prog_in;
  logic       prog_en;
  logic       prog_out;
  logic       busy;
  logic       done;
  logic       verify_ok;

  logic [15:0] chain;
  logic        forceZero;
  int          enCount;
  int          doneCount;
  logic        okAtDone;
  int          enBase;
  int          doneBase;
  int          assertCount;
  int          failCount;

  config_chain_loader #(
    .CHAIN_LEN (16),
    .WORD_W    (8)
  ) dut (
    .prog_clk_i  (prog_clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .verify_en_i (verify_en),
    .cfg_valid_i (cfg_valid),
    .cfg_data_i  (cfg_data),
    .cfg_ready_o (cfg_ready),
    .prog_in_o   (prog_in),
    .prog_en_o   (prog_en),
    .prog_out_i  (prog_out),
    .busy_o      (busy),
    .done_o      (done),
    .verify_ok_o (verify_ok)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // Chain model: bits enter at the top and leave at bit 0.
  always @(posedge prog_clk) begin
    if (prog_en) chain <= {prog_in, chain[15:1]};
  end
  assign prog_out = forceZero ? 1'b0 : chain[0];

  always @(negedge prog_clk) begin
    if (prog_en) enCount++;
    if (done) begin
      doneCount++;
      okAtDone = verify_ok;
    end
  end

  task automatic tick;
    @(negedge prog_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      $error("[TB] assertion %s", tag);
    end
  endtask

  // Runs one complete load and waits (bounded) for the done pulse plus two settling cycles.
  task automatic applyStimulus(input logic [7:0] w0, input logic [7:0] w1, input logic ver,
                               input logic gap, input logic startInShift);
    enBase   = enCount;
    doneBase = doneCount;
    tick;
    start     = 1'b1;
    verify_en = ver;
    tick;
    start     = 1'b0;
    verify_en = 1'b0;
    checkOutput("readyFill", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_data  = w0;
    tick;
    if (gap) begin
      cfg_valid = 1'b0;
      cfg_data  = 8'h00;
      tick;
      checkOutput("readyGap", 32'(cfg_ready), 32'd1);
      cfg_valid = 1'b1;
    end
    cfg_data = w1;
    tick;
    cfg_valid = 1'b0;
    cfg_data  = 8'h00;
    checkOutput("firstEn", 32'(prog_en), 32'd1);
    for (int c = 0; c < 200 && doneCount == doneBase; c++) begin
      start = (startInShift && c == 3);
      tick;
    end
    start = 1'b0;
    checkOutput("doneSeen", 32'(doneCount - doneBase), 32'd1);
    tick;
    tick;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    enCount     = 0;
    doneCount   = 0;
    okAtDone    = 1'b0;
    forceZero   = 1'b0;
    chain       = 16'h0000;
    rst_n       = 1'b0;
    start       = 1'b0;
    verify_en   = 1'b0;
    cfg_valid   = 1'b0;
    cfg_data    = 8'h00;

    #1;
    checkOutput("rstReady", 32'(cfg_ready), 32'd0);
    checkOutput("rstProgEn", 32'(prog_en), 32'd0);
    checkOutput("rstProgIn", 32'(prog_in), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstOk", 32'(verify_ok), 32'd0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;

    $display("[TB] step 1: verified load 0xA5 0x3C");
    applyStimulus(8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0);
    checkOutput("t1EnCount", 32'(enCount - enBase), 32'd32);
    checkOutput("t1Chain", 32'(chain), 32'h3CA5);
    checkOutput("t1OkAtDone", 32'(okAtDone), 32'd1);
    checkOutput("t1OkHeld", 32'(verify_ok), 32'd1);
    checkOutput("t1Busy", 32'(busy), 32'd0);

    $display("[TB] step 2: readback forced low");
    forceZero = 1'b1;
    applyStimulus(8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0);
    forceZero = 1'b0;
    checkOutput("t2EnCount", 32'(enCount - enBase), 32'd32);
    checkOutput("t2Chain", 32'(chain), 32'h3CA5);
    checkOutput("t2OkAtDone", 32'(okAtDone), 32'd0);

    $display("[TB] step 3: load without readback 0xFF 0x00");
    applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("t3EnCount", 32'(enCount - enBase), 32'd16);
    checkOutput("t3Chain", 32'(chain), 32'h00FF);
    checkOutput("t3OkAtDone", 32'(okAtDone), 32'd0);

    $display("[TB] step 4: gapped host words");
    applyStimulus(8'hA5, 8'h3C, 1'b1, 1'b1, 1'b0);
    checkOutput("t4EnCount", 32'(enCount - enBase), 32'd32);
    checkOutput("t4Chain", 32'(chain), 32'h3CA5);
    checkOutput("t4OkAtDone", 32'(okAtDone), 32'd1);

    $display("[TB] step 5: start pulsed during shift");
    applyStimulus(8'h5A, 8'hC3, 1'b1, 1'b0, 1'b1);
    checkOutput("t5EnCount", 32'(enCount - enBase), 32'd32);
    checkOutput("t5DoneCount", 32'(doneCount - doneBase), 32'd1);
    checkOutput("t5Chain", 32'(chain), 32'hC35A);
    checkOutput("t5OkAtDone", 32'(okAtDone), 32'd1);
    checkOutput("t5Busy", 32'(busy), 32'd0);

    $display("[TB] step 6: reset in the middle of shifting");
    enBase = enCount;
    tick;
    start     = 1'b1;
    verify_en = 1'b1;
    tick;
    start     = 1'b0;
    verify_en = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = 8'h11;
    tick;
    cfg_data  = 8'h22;
    tick;
    cfg_valid = 1'b0;
    for (int c = 0; c < 50 && (enCount - enBase) < 5; c++) tick;
    checkOutput("t6FiveShifts", 32'(enCount - enBase), 32'd5);
    rst_n = 1'b0;
    #1;
    checkOutput("t6RstProgEn", 32'(prog_en), 32'd0);
    checkOutput("t6RstBusy", 32'(busy), 32'd0);
    checkOutput("t6RstReady", 32'(cfg_ready), 32'd0);
    tick;
    rst_n = 1'b1;
    tick;
    applyStimulus(8'hA5, 8'h3C, 1'b1, 1'b0, 1'b0);
    checkOutput("t6EnCount", 32'(enCount - enBase), 32'd32);
    checkOutput("t6Chain", 32'(chain), 32'h3CA5);
    checkOutput("t6OkAtDone", 32'(okAtDone), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
